// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_ctrl
// Description : Register-file writeback queue. It merges requests from the
//               integer ALU (A) and the FP unit (B) into a DEPTH-entry FIFO,
//               drains one entry per cycle onto the register-file write port,
//               and forwards the youngest pending data to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_ws,
    input  logic [31:0] a_wd,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_ws,
    input  logic [31:0] b_wd,
    input  logic        stall,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data,
    output logic [31:0] busy_mask,
    output logic [4:0]  ws,
    output logic [31:0] wd,
    output logic        wf,
    output logic [3:0]  count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0]         r_q_ws [DEPTH];
    logic [31:0]        r_q_wd [DEPTH];
    logic [c_PTR_W-1:0] r_wp;
    logic [c_PTR_W-1:0] r_rp;
    logic [3:0]         r_count;
    logic [4:0]         r_ws;
    logic [31:0]        r_wd;
    logic               r_wf;
    logic [31:0]        r_busy;

    logic [3:0]         w_free;
    logic               w_a_acc;
    logic               w_b_acc;
    logic [1:0]         w_n_acc;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_b_slot;
    logic [c_PTR_W-1:0] w_wp_nxt;
    logic [c_PTR_W-1:0] w_rp_nxt;
    logic [3:0]         w_count_nxt;
    logic [31:0]        w_busy_nxt;
    logic [c_PTR_W-1:0] w_bidx;
    logic [4:0]         w_bws;
    logic [c_PTR_W-1:0] w_fidx;
    logic               w_f1_hit;
    logic               w_f2_hit;
    logic [31:0]        w_f1_data;
    logic [31:0]        w_f2_data;

    // Credit is taken from the registered count only; a pop this cycle frees nothing yet.
    assign w_free   = 4'(DEPTH) - r_count;
    assign a_ready  = (w_free >= 4'd1);
    assign b_ready  = (w_free >= 4'd2) || ((w_free == 4'd1) && !a_valid);
    // Nothing is accepted while reset is asserted even though ready may be high.
    assign w_a_acc  = a_valid && a_ready && rst_n;
    assign w_b_acc  = b_valid && b_ready && rst_n;
    assign w_n_acc  = {1'b0, w_a_acc} + {1'b0, w_b_acc};
    assign w_pop    = (r_count != 4'd0) && !stall;
    // A lands first, so B takes the slot after it when both are accepted.
    assign w_b_slot = r_wp + c_PTR_W'(w_a_acc);
    assign w_wp_nxt = r_wp + c_PTR_W'(w_n_acc);
    assign w_rp_nxt = r_rp + c_PTR_W'(w_pop);
    assign w_count_nxt = r_count + 4'(w_n_acc) - 4'(w_pop);

    // Next-cycle busy mask, built from the queue contents after this edge's push/pop.
    always_comb begin
        w_busy_nxt = '0;
        w_bidx     = '0;
        w_bws      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_bidx = w_rp_nxt + c_PTR_W'(k);
            if (w_a_acc && (w_bidx == r_wp)) begin
                w_bws = a_ws;
            end else if (w_b_acc && (w_bidx == w_b_slot)) begin
                w_bws = b_ws;
            end else begin
                w_bws = r_q_ws[w_bidx];
            end
            if (4'(k) < w_count_nxt) begin
                w_busy_nxt[w_bws] = 1'b1;
            end
        end
    end

    // Forwarding: output stage first, then queue oldest-to-newest so the youngest match wins.
    always_comb begin
        w_f1_hit  = 1'b0;
        w_f2_hit  = 1'b0;
        w_f1_data = '0;
        w_f2_data = '0;
        w_fidx    = '0;
        if (!r_wf && (r_ws == rs1)) begin
            w_f1_hit  = 1'b1;
            w_f1_data = r_wd;
        end
        if (!r_wf && (r_ws == rs2)) begin
            w_f2_hit  = 1'b1;
            w_f2_data = r_wd;
        end
        for (int k = 0; k < DEPTH; k++) begin
            w_fidx = r_rp + c_PTR_W'(k);
            if (4'(k) < r_count) begin
                if (r_q_ws[w_fidx] == rs1) begin
                    w_f1_hit  = 1'b1;
                    w_f1_data = r_q_wd[w_fidx];
                end
                if (r_q_ws[w_fidx] == rs2) begin
                    w_f2_hit  = 1'b1;
                    w_f2_data = r_q_wd[w_fidx];
                end
            end
        end
    end

    // Queue storage; contents need no reset since validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (w_a_acc) begin
            r_q_ws[r_wp] <= a_ws;
            r_q_wd[r_wp] <= a_wd;
        end
        if (w_b_acc) begin
            r_q_ws[w_b_slot] <= b_ws;
            r_q_wd[w_b_slot] <= b_wd;
        end
    end

    // Pointers, occupancy, busy mask and the registered register-file write stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_wf    <= 1'b1;
            r_ws    <= '0;
            r_wd    <= '0;
        end else begin
            r_wp    <= w_wp_nxt;
            r_rp    <= w_rp_nxt;
            r_count <= w_count_nxt;
            r_busy  <= w_busy_nxt;
            if (w_pop) begin
                r_ws <= r_q_ws[r_rp];
                r_wd <= r_q_wd[r_rp];
                r_wf <= 1'b0;
            end else begin
                r_wf <= 1'b1;
            end
        end
    end

    assign fwd1_hit  = w_f1_hit;
    assign fwd2_hit  = w_f2_hit;
    assign fwd1_data = w_f1_data;
    assign fwd2_data = w_f2_data;
    assign busy_mask = r_busy;
    assign ws        = r_ws;
    assign wd        = r_wd;
    assign wf        = r_wf;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_ctrl
// Description : Directed self-checking bench for regfile_wb_ctrl (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_ws;
    logic [31:0] a_wd;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_ws;
    logic [31:0] b_wd;
    logic        stall;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
    logic [31:0] busy_mask;
    logic [4:0]  ws;
    logic [31:0] wd;
    logic        wf;
    logic [3:0]  count;

    int checks;
    int failures;

    regfile_wb_ctrl #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_ws      (a_ws),
        .a_wd      (a_wd),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_ws      (b_ws),
        .b_wd      (b_wd),
        .stall     (stall),
        .rs1       (rs1),
        .rs2       (rs2),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data),
        .busy_mask (busy_mask),
        .ws        (ws),
        .wd        (wd),
        .wf        (wf),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; a_ws = 5'd9; a_wd = 32'h99;
        step(); step(); #1;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (wf !== 1'b1) begin failures++; $display("FAIL rst_wf got=%b exp=1", wf); end
        checks++; if (ws !== 5'd0 || wd !== 32'd0) begin failures++; $display("FAIL rst_wswd got=%0d/%h exp=0/0", ws, wd); end
        checks++; if (busy_mask !== 32'd0) begin failures++; $display("FAIL rst_busy got=%h exp=0", busy_mask); end
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b%b exp=11", a_ready, b_ready); end
        a_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_ws = 5'd3; a_wd = 32'h41B80000; #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", a_ready); end
        step(); a_valid = 1'b0; #1;
        checks++; if (count !== 4'd1 || wf !== 1'b1 || busy_mask !== 32'h8) begin
            failures++; $display("FAIL single_queued got cnt=%0d wf=%b busy=%h exp cnt=1 wf=1 busy=8", count, wf, busy_mask); end
        step();
        checks++; if (wf !== 1'b0 || ws !== 5'd3 || wd !== 32'h41B80000 || busy_mask !== 32'd0) begin
            failures++; $display("FAIL single_write got wf=%b ws=%0d wd=%h busy=%h exp 0/3/41b80000/0", wf, ws, wd, busy_mask); end
        step();
        checks++; if (wf !== 1'b1 || ws !== 5'd3 || wd !== 32'h41B80000 || count !== 4'd0) begin
            failures++; $display("FAIL single_after got wf=%b ws=%0d wd=%h cnt=%0d exp 1/3/41b80000/0", wf, ws, wd, count); end
    endtask

    task automatic test_dual();
        a_valid = 1'b1; a_ws = 5'd5; a_wd = 32'h1;
        b_valid = 1'b1; b_ws = 5'd5; b_wd = 32'h2; #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL dual_ready got=%b%b exp=11", a_ready, b_ready); end
        step(); a_valid = 1'b0; b_valid = 1'b0; rs1 = 5'd5; #1;
        checks++; if (count !== 4'd2 || fwd1_hit !== 1'b1 || fwd1_data !== 32'h2) begin
            failures++; $display("FAIL dual_fwd_q got cnt=%0d hit=%b data=%h exp 2/1/2", count, fwd1_hit, fwd1_data); end
        step();
        checks++; if (wf !== 1'b0 || wd !== 32'h1 || fwd1_data !== 32'h2 || count !== 4'd1) begin
            failures++; $display("FAIL dual_first got wf=%b wd=%h fwd=%h cnt=%0d exp 0/1/2/1", wf, wd, fwd1_data, count); end
        step();
        checks++; if (wf !== 1'b0 || ws !== 5'd5 || wd !== 32'h2 || fwd1_hit !== 1'b1 || fwd1_data !== 32'h2) begin
            failures++; $display("FAIL dual_second got wf=%b ws=%0d wd=%h fwd=%b/%h exp 0/5/2/1/2", wf, ws, wd, fwd1_hit, fwd1_data); end
        step();
        checks++; if (wf !== 1'b1 || fwd1_hit !== 1'b0 || fwd1_data !== 32'd0) begin
            failures++; $display("FAIL dual_idle got wf=%b fwd=%b/%h exp 1/0/0", wf, fwd1_hit, fwd1_data); end
        rs1 = 5'd31;
    endtask

    task automatic test_forward();
        stall = 1'b1; rs2 = 5'd7; #1;
        checks++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'd0) begin failures++; $display("FAIL fwd_miss got=%b/%h exp 0/0", fwd2_hit, fwd2_data); end
        a_valid = 1'b1; a_ws = 5'd7; a_wd = 32'hDEAD;
        step(); a_valid = 1'b0; #1;
        checks++; if (fwd2_hit !== 1'b1 || fwd2_data !== 32'hDEAD) begin failures++; $display("FAIL fwd_hit got=%b/%h exp 1/dead", fwd2_hit, fwd2_data); end
        a_valid = 1'b1; a_wd = 32'hBEEF;
        step(); a_valid = 1'b0; #1;
        checks++; if (fwd2_data !== 32'hBEEF || busy_mask !== 32'h80 || wf !== 1'b1) begin
            failures++; $display("FAIL fwd_young got data=%h busy=%h wf=%b exp beef/80/1", fwd2_data, busy_mask, wf); end
        stall = 1'b0;
        step();
        checks++; if (wf !== 1'b0 || wd !== 32'hDEAD || fwd2_data !== 32'hBEEF) begin
            failures++; $display("FAIL fwd_q_over_out got wf=%b wd=%h fwd=%h exp 0/dead/beef", wf, wd, fwd2_data); end
        step(); step();
        checks++; if (wf !== 1'b1 || fwd2_hit !== 1'b0) begin failures++; $display("FAIL fwd_clear got wf=%b hit=%b exp 1/0", wf, fwd2_hit); end
        rs2 = 5'd31;
    endtask

    task automatic test_full();
        int nw;
        logic will;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_ws = 5'(10 + i); a_wd = 32'h100 + 32'(i); #1;
            checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL full_ready%0d got=%b exp=1", i, a_ready); end
            step();
        end
        a_ws = 5'd14; a_wd = 32'h104; #1;
        checks++; if (count !== 4'd4 || a_ready !== 1'b0 || b_ready !== 1'b0 || busy_mask !== 32'h3C00) begin
            failures++; $display("FAIL full_state got cnt=%0d ar=%b br=%b busy=%h exp 4/0/0/3c00", count, a_ready, b_ready, busy_mask); end
        step();
        checks++; if (count !== 4'd4 || wf !== 1'b1) begin failures++; $display("FAIL full_hold got cnt=%0d wf=%b exp 4/1", count, wf); end
        stall = 1'b0;
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            will = a_valid && a_ready;
            step();
            if (will) a_valid = 1'b0;
            if (wf === 1'b0) begin
                checks++;
                if (nw >= 5 || ws !== 5'(10 + nw) || wd !== 32'h100 + 32'(nw)) begin
                    failures++; $display("FAIL full_drain%0d got ws=%0d wd=%h exp %0d/%h", nw, ws, wd, 10 + nw, 32'h100 + 32'(nw)); end
                nw++;
            end
        end
        checks++; if (nw != 5 || count !== 4'd0 || a_valid !== 1'b0) begin
            failures++; $display("FAIL full_total got writes=%0d cnt=%0d exp 5/0", nw, count); end
    endtask

    task automatic test_back_to_back();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_ws = 5'(20 + i); a_wd = 32'h200 + 32'(i);
            step();
        end
        a_ws = 5'd23; a_wd = 32'h203;
        b_valid = 1'b1; b_ws = 5'd24; b_wd = 32'h204; #1;
        checks++; if (count !== 4'd3 || a_ready !== 1'b1 || b_ready !== 1'b0) begin
            failures++; $display("FAIL slot_both got cnt=%0d ar=%b br=%b exp 3/1/0", count, a_ready, b_ready); end
        step(); a_valid = 1'b0; #1;
        checks++; if (count !== 4'd4 || b_ready !== 1'b0) begin failures++; $display("FAIL slot_a_only got cnt=%0d br=%b exp 4/0", count, b_ready); end
        stall = 1'b0;
        step(); stall = 1'b1; #1;
        checks++; if (count !== 4'd3 || wf !== 1'b0 || ws !== 5'd20 || b_ready !== 1'b1) begin
            failures++; $display("FAIL slot_pop got cnt=%0d wf=%b ws=%0d br=%b exp 3/0/20/1", count, wf, ws, b_ready); end
        step(); b_valid = 1'b0; #1;
        checks++; if (count !== 4'd4 || wf !== 1'b1 || busy_mask !== 32'h01E00000) begin
            failures++; $display("FAIL slot_b_acc got cnt=%0d wf=%b busy=%h exp 4/1/01e00000", count, wf, busy_mask); end
        stall = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            checks++; if (wf !== 1'b0 || ws !== 5'(21 + j) || wd !== 32'h201 + 32'(j)) begin
                failures++; $display("FAIL b2b_%0d got wf=%b ws=%0d wd=%h exp 0/%0d/%h", j, wf, ws, wd, 21 + j, 32'h201 + 32'(j)); end
        end
        step();
        checks++; if (wf !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL b2b_end got wf=%b cnt=%0d exp 1/0", wf, count); end
    endtask

    task automatic test_reg0();
        a_valid = 1'b1; a_ws = 5'd0; a_wd = 32'h55; rs1 = 5'd0;
        step(); a_valid = 1'b0; #1;
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h55 || busy_mask !== 32'h1) begin
            failures++; $display("FAIL reg0_fwd got=%b/%h busy=%h exp 1/55/1", fwd1_hit, fwd1_data, busy_mask); end
        step();
        checks++; if (wf !== 1'b0 || ws !== 5'd0 || wd !== 32'h55) begin
            failures++; $display("FAIL reg0_write got wf=%b ws=%0d wd=%h exp 0/0/55", wf, ws, wd); end
        step();
        rs1 = 5'd31;
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_ws = 5'(1 + i); a_wd = 32'h301 + 32'(i);
            step();
        end
        a_valid = 1'b0; #1;
        checks++; if (count !== 4'd3) begin failures++; $display("FAIL rmid_fill got cnt=%0d exp 3", count); end
        rst_n = 1'b0; stall = 1'b0;
        step(); rst_n = 1'b1; #1;
        checks++; if (count !== 4'd0 || wf !== 1'b1 || busy_mask !== 32'd0 || ws !== 5'd0 || wd !== 32'd0) begin
            failures++; $display("FAIL rmid_state got cnt=%0d wf=%b busy=%h ws=%0d wd=%h exp 0/1/0/0/0", count, wf, busy_mask, ws, wd); end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (wf !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL rmid_quiet%0d got wf=%b cnt=%0d exp 1/0", c, wf, count); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; a_valid = 1'b0; a_ws = '0; a_wd = '0;
        b_valid = 1'b0; b_ws = '0; b_wd = '0; stall = 1'b0;
        rs1 = 5'd31; rs2 = 5'd31;
        test_reset();
        test_single();
        test_dual();
        test_forward();
        test_full();
        test_back_to_back();
        test_reg0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
